// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring, both on unsigned magnitudes,
// with one iteration per cycle followed by a single sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   input  logic             hilo_rd,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

   stateT             state, nextState;
   logic [CW-1:0]     counter;

   // Working register: upper half is the partial product / remainder,
   // lower half is the multiplier / dividend being shifted out.
   logic [2*WIDTH-1:0] work;
   logic [WIDTH-1:0]   operand;   // |multiplicand| or |divisor|
   logic [WIDTH-1:0]   rawA;      // srca as given, for divide by zero
   logic               divMode;
   logic               negRes;
   logic               negRem;
   logic               divZero;

   logic               acceptOp, arithStart, writeResult, signedOp;
   logic [WIDTH-1:0]   absA, absB;
   logic [WIDTH:0]     mulSum, divShift, divDiff;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quotFix, remFix;

   assign acceptOp    = (state == IDLE) && start && !flush;
   assign arithStart  = acceptOp && !op[2];
   assign writeResult = (state == FIX) && !flush;
   assign signedOp    = !op[0];
   assign absA        = (signedOp && srca[WIDTH-1]) ? -srca : srca;
   assign absB        = (signedOp && srcb[WIDTH-1]) ? -srcb : srcb;

   assign busy  = (state != IDLE);
   assign stall = busy && (start || hilo_rd);

   // State register and iteration counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         done    <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         state   <= nextState;
         done    <= writeResult;
         if (arithStart)
            counter <= CW'(WIDTH - 1);
         else if (state == CALC)
            counter <= counter - 1'b1;
      end
   end

   // Next-state logic; flush drops any in-flight op back to IDLE.
   always_comb begin
      // NOTE: default first so no path through the case leaves nextState unassigned (no latch).
      nextState = state;
      case (state)
         IDLE:    if (arithStart) nextState = CALC;
         CALC:    if (flush) nextState = IDLE;
                  else if (counter == '0) nextState = FIX;
         FIX:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // One shift-add or restoring-subtract step, plus the sign-fixed results.
   always_comb begin
      mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
      divShift = work[2*WIDTH-1:WIDTH-1];
      divDiff  = divShift - {1'b0, operand};
      prodFix  = negRes ? -work : work;
      quotFix  = negRes ? -work[WIDTH-1:0] : work[WIDTH-1:0];
      remFix   = negRem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
   end

   // Datapath registers: loaded on acceptance, iterated in CALC.
   // NOTE: no reset here; these are always loaded before use and are never visible outside.
   always_ff @(posedge clk) begin
      if (arithStart) begin
         work    <= {{WIDTH{1'b0}}, absA};
         operand <= absB;
         rawA    <= srca;
         divMode <= op[1];
         negRes  <= signedOp && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
         negRem  <= signedOp && srca[WIDTH-1];
         divZero <= (srcb == '0);
      end else if (state == CALC) begin
         if (!divMode)
            work <= {mulSum, work[WIDTH-1:1]};
         else if (!divDiff[WIDTH])
            work <= {divDiff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
         else
            work <= {divShift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      end
   end

   // Architectural HI/LO: MTHI/MTLO in IDLE, results on the FIX exit edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (acceptOp && op == OP_MTHI) begin
         hi <= srca;
      end else if (acceptOp && op == OP_MTLO) begin
         lo <= srca;
      end else if (writeResult) begin
         if (!divMode) begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
         end else if (divZero) begin
            hi <= rawA;
            lo <= '1;
         end else begin
            hi <= remFix;
            lo <= quotFix;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec cases, randomized
// MULT/DIV against an arithmetic reference model, flush, stall and reset.
module tb_muldiv_unit;

   localparam int W = 32;
   localparam int LAT = W + 1;   // busy cycles per MULT/DIV

   logic          clk = 1'b0;
   logic          reset, start, flush, hilo_rd;
   logic [2:0]    op;
   logic [W-1:0]  srca, srcb, hi, lo;
   logic          busy, done, stall;

   int checks = 0;
   int failures = 0;

   // Architectural HI/LO as the bench believes they should be.
   logic [W-1:0]  modelHi = '0;
   logic [W-1:0]  modelLo = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .flush(flush), .hilo_rd(hilo_rd), .hi(hi), .lo(lo), .busy(busy), .done(done),
      .stall(stall)
   );

   always #5 clk = ~clk;

   // Reference result {hi, lo} for a MULT/DIV op, from plain integer arithmetic.
   function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
      longint        sa, sb, q, r;
      logic [63:0]   ua, ub, res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      res = '0;
      case (o)
         3'd0: res = sa * sb;
         3'd1: res = ua * ub;
         3'd2: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {ub[31:0] == 0 ? 32'h0 : (a % b), a / b};
         end
         default: res = {modelHi, modelLo};
      endcase
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one MULT/DIV, check latency, done pulse and result.
   task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name);
      logic [63:0] expv;
      int cycles;
      expv = refModel(o, a, b);
      op = o; srca = a; srcb = b; start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         if (hilo_rd) begin
            checks++;
            if (stall !== 1'b1) begin
               failures++;
               $display("FAIL %s stall: got %b expected 1 (busy cycle %0d)", name, stall, cycles);
            end
         end
         cycles++;
         tick();
      end
      checks++;
      if (cycles !== LAT) begin
         failures++;
         $display("FAIL %s latency: got %0d busy cycles expected %0d", name, cycles, LAT);
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s done: got %b expected 1", name, done);
      end
      checks++;
      if (hi !== expv[63:32] || lo !== expv[31:0]) begin
         failures++;
         $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h (a=%h b=%h)",
                  name, hi, lo, expv[63:32], expv[31:0], a, b);
      end
      modelHi = expv[63:32];
      modelLo = expv[31:0];
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL %s done_pulse: got %b expected 0", name, done);
      end
   endtask

   // One-edge op in IDLE (MTHI/MTLO/no-op), optionally under flush.
   task automatic idleOp(input logic [2:0] o, input logic [31:0] a, input logic fl,
                         input string name);
      op = o; srca = a; srcb = '0; start = 1'b1; flush = fl;
      tick();
      start = 1'b0; flush = 1'b0;
      if (!fl && o == 3'b100) modelHi = a;
      if (!fl && o == 3'b101) modelLo = a;
      checks++;
      if (hi !== modelHi || lo !== modelLo || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s: got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                  name, hi, lo, busy, done, modelHi, modelLo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; flush = 1'b0; hilo_rd = 1'b0;
      op = '0; srca = '0; srcb = '0;
      repeat (2) tick();
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b expected all 0",
                  hi, lo, busy, done, stall);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      runOp(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
      runOp(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
      runOp(3'd3, 32'd100, 32'd0, "divu_by_zero");
      runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      runOp(3'd2, 32'hFFFF_FFF9, 32'd0, "div_signed_by_zero");
   endtask

   task automatic test_random();
      logic [31:0] v [2];
      logic [2:0]  o;
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 5))
               0: v[k] = 32'h0;
               1: v[k] = 32'h8000_0000;
               2: v[k] = 32'hFFFF_FFFF;
               3: v[k] = 32'($urandom_range(0, 20));
               default: v[k] = $urandom;
            endcase
         end
         o = 3'($urandom_range(0, 3));
         runOp(o, v[0], v[1], "random");
      end
   endtask

   task automatic test_mt_sequence();
      idleOp(3'b100, 32'h0000_1234, 1'b0, "mthi");
      idleOp(3'b101, 32'hCAFE_F00D, 1'b0, "mtlo");
      idleOp(3'b110, 32'h1111_1111, 1'b0, "noop_op6");
      hilo_rd = 1'b1;
      runOp(3'd3, 32'd9, 32'd4, "divu_9by4_hilo_rd");
      hilo_rd = 1'b0;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL stall_after_busy: got %b expected 0", stall);
      end
   endtask

   task automatic test_flush();
      logic sawDone;
      idleOp(3'b100, 32'hAAAA_0000, 1'b0, "preload_hi");
      idleOp(3'b101, 32'h0000_5555, 1'b0, "preload_lo");
      // Flush in CALC cycle 10.
      op = 3'd1; srca = 32'd6; srcb = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== modelHi || lo !== modelLo) begin
         failures++;
         $display("FAIL flush_calc: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                  busy, hi, lo, modelHi, modelLo);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) sawDone = 1'b1;
         tick();
      end
      checks++;
      if (sawDone !== 1'b0 || hi !== modelHi || lo !== modelLo) begin
         failures++;
         $display("FAIL flush_calc_nodone: got done_seen=%b hi=%h lo=%h expected 0 %h %h",
                  sawDone, hi, lo, modelHi, modelLo);
      end
      // Flush during FIX.
      op = 3'd1; srca = 32'd6; srcb = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (W) tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL fix_reached: got busy=%b expected 1", busy);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== modelHi || lo !== modelLo) begin
         failures++;
         $display("FAIL flush_fix: got busy=%b done=%b hi=%h lo=%h expected 0 0 %h %h",
                  busy, done, hi, lo, modelHi, modelLo);
      end
      // Flush in IDLE suppresses MTHI and MULT alike.
      idleOp(3'b100, 32'hDEAD_BEEF, 1'b1, "flush_idle_mthi");
      idleOp(3'd0, 32'd3, 1'b1, "flush_idle_mult");
   endtask

   task automatic test_back_to_back();
      int cycles;
      op = 3'd1; srca = 32'd2; srcb = 32'd3; start = 1'b1;
      tick();
      // Re-present a different op and hold start while busy.
      op = 3'd3; srca = 32'd100; srcb = 32'd7;
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         checks++;
         if (stall !== 1'b1) begin
            failures++;
            $display("FAIL start_busy_stall: got %b expected 1 (cycle %0d)", stall, cycles);
         end
         cycles++;
         tick();
      end
      modelHi = 32'd0;
      modelLo = 32'd6;
      checks++;
      if (cycles !== LAT || done !== 1'b1 || hi !== modelHi || lo !== modelLo || stall !== 1'b0) begin
         failures++;
         $display("FAIL start_busy_first: got cycles=%0d done=%b hi=%h lo=%h stall=%b expected %0d 1 %h %h 0",
                  cycles, done, hi, lo, stall, LAT, modelHi, modelLo);
      end
      tick();
      start = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         tick();
      end
      modelHi = 32'd2;
      modelLo = 32'd14;
      checks++;
      if (cycles !== LAT || done !== 1'b1 || hi !== modelHi || lo !== modelLo) begin
         failures++;
         $display("FAIL start_busy_second: got cycles=%0d done=%b hi=%h lo=%h expected %0d 1 %h %h",
                  cycles, done, hi, lo, LAT, modelHi, modelLo);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      op = 3'd0; srca = 32'h1234_5678; srcb = 32'h0000_0ABC; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      modelHi = '0;
      modelLo = '0;
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_midop: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0",
                  hi, lo, busy, done);
      end
      #2 reset = 1'b0;
      tick();
      runOp(3'd0, 32'd2, 32'd3, "mult_after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mt_sequence();
      test_flush();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
